wb_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources: requester 0 (ALU result) and requester 1 (memory load).
- Each source has its own small FIFO. A round-robin arbiter drains one entry per cycle into a registered write stage that drives reg_wr_en, reg_wr_dest and reg_wr_data.
- Exports a pending-write mask so decode can stall readers of registers that are not yet written back.

---
 rtl/wb_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: two requester FIFOs drained round-robin into a
// registered write stage, with a pending-write mask for decode-side stalling.
module wb_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_dest,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_dest,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   reg_wr_en,
  output logic [ADDR_W-1:0]      reg_wr_dest,
  output logic [DATA_W-1:0]      reg_wr_data,
  output logic [2**ADDR_W-1:0]   pend_mask,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);

  logic [1:0]        in_valid, ready, push, pop, head_vld;
  logic [ADDR_W-1:0] in_dest [2];
  logic [DATA_W-1:0] in_data [2];

  // Per-slot valid bits carry the FIFO occupancy; storage itself is unreset.
  logic [DEPTH-1:0]  vld    [2];
  logic [PW-1:0]     wr_ptr [2];
  logic [PW-1:0]     rd_ptr [2];
  logic [ADDR_W-1:0] q_dest [2][DEPTH];
  logic [DATA_W-1:0] q_data [2][DEPTH];

  logic              rr_last, gnt_vld, gnt_idx, err_evt;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;

  assign in_valid   = {mem_valid, alu_valid};
  assign in_dest[0] = alu_dest;
  assign in_dest[1] = mem_dest;
  assign in_data[0] = alu_data;
  assign in_data[1] = mem_data;
  assign alu_ready  = ready[0];
  assign mem_ready  = ready[1];

  always_comb begin
    ready    = '0;
    head_vld = '0;
    for (int i = 0; i < 2; i++) begin
      ready[i]    = ~&vld[i];
      head_vld[i] = vld[i][rd_ptr[i]];
    end
  end

  assign push = in_valid & ready;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    gnt_vld = |head_vld;
    gnt_idx = 1'b0;
    if (&head_vld)       gnt_idx = ~rr_last;
    else if (head_vld[1]) gnt_idx = 1'b1;
  end

  assign pop       = {gnt_vld & gnt_idx, gnt_vld & ~gnt_idx};
  assign head_dest = q_dest[gnt_idx][rd_ptr[gnt_idx]];
  assign head_data = q_data[gnt_idx][rd_ptr[gnt_idx]];

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        vld[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          vld[i][wr_ptr[i]] <= 1'b1;
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          vld[i][rd_ptr[i]] <= 1'b0;
          rd_ptr[i]         <= rd_ptr[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        q_dest[i][wr_ptr[i]] <= in_dest[i];
        q_data[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  // Built from registered state only, so decode never sees a path from *_valid.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < DEPTH; s++)
        if (vld[i][s]) pend_mask[q_dest[i][s]] = 1'b1;
    if (reg_wr_en) pend_mask[reg_wr_dest] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  always_comb begin
    err_evt = 1'b0;
    for (int i = 0; i < 2; i++)
      if (push[i] && in_dest[i] != '0 && pend_mask[in_dest[i]]) err_evt = 1'b1;
    if (&push && in_dest[0] == in_dest[1] && in_dest[0] != '0) err_evt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_en   <= 1'b0;
      reg_wr_dest <= '0;
      reg_wr_data <= '0;
      rr_last     <= 1'b1;
      err         <= 1'b0;
    end else begin
      if (gnt_vld) begin
        reg_wr_en   <= (head_dest != '0);
        reg_wr_dest <= head_dest;
        reg_wr_data <= head_data;
        rr_last     <= gnt_idx;
      end else begin
        reg_wr_en   <= 1'b0;
      end
      if (err_evt) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: queue-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_write_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;
  localparam int NREG   = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              alu_valid = 1'b0, mem_valid = 1'b0;
  logic [ADDR_W-1:0] alu_dest = '0, mem_dest = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
  logic              alu_ready, mem_ready, reg_wr_en, err;
  logic [ADDR_W-1:0] reg_wr_dest;
  logic [DATA_W-1:0] reg_wr_data;
  logic [NREG-1:0]   pend_mask;

  int checks = 0;
  int errors = 0;

  wb_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .reg_wr_en(reg_wr_en), .reg_wr_dest(reg_wr_dest), .reg_wr_data(reg_wr_data),
    .pend_mask(pend_mask), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester, last-winner register, write stage.
  entry_t          q0[$], q1[$];
  logic            m_last = 1'b1;
  logic            m_en = 1'b0, m_err = 1'b0;
  logic [ADDR_W-1:0] m_dest = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic [ADDR_W-1:0] wlog[$];

  function automatic logic [NREG-1:0] model_pend();
    logic [NREG-1:0] p = '0;
    foreach (q0[k]) p[q0[k].dest] = 1'b1;
    foreach (q1[k]) p[q1[k].dest] = 1'b1;
    if (m_en) p[m_dest] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q0.delete(); q1.delete();
        m_last = 1'b1; m_en = 1'b0; m_err = 1'b0; m_dest = '0; m_data = '0;
      end else begin
        logic [NREG-1:0] p;
        logic acc0, acc1;
        entry_t e;
        p    = model_pend();
        acc0 = alu_valid && (q0.size() < DEPTH);
        acc1 = mem_valid && (q1.size() < DEPTH);
        if (acc0 && alu_dest != 0 && p[alu_dest]) m_err = 1'b1;
        if (acc1 && mem_dest != 0 && p[mem_dest]) m_err = 1'b1;
        if (acc0 && acc1 && alu_dest == mem_dest && alu_dest != 0) m_err = 1'b1;
        if (q0.size() > 0 || q1.size() > 0) begin
          logic g;
          if (q0.size() > 0 && q1.size() > 0) g = ~m_last;
          else g = (q1.size() > 0);
          e = g ? q1.pop_front() : q0.pop_front();
          m_last = g;
          m_en   = (e.dest != 0);
          m_dest = e.dest;
          m_data = e.data;
        end else begin
          m_en = 1'b0;
        end
        if (acc0) q0.push_back('{alu_dest, alu_data});
        if (acc1) q1.push_back('{mem_dest, mem_data});
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("alu_ready", 32'(alu_ready), 32'(q0.size() < DEPTH));
      check("mem_ready", 32'(mem_ready), 32'(q1.size() < DEPTH));
      check("reg_wr_en", 32'(reg_wr_en), 32'(m_en));
      check("reg_wr_dest", 32'(reg_wr_dest), 32'(m_dest));
      check("reg_wr_data", 32'(reg_wr_data), 32'(m_data));
      check("pend_mask", 32'(pend_mask), 32'(model_pend()));
      check("err", 32'(err), 32'(m_err));
      if (reg_wr_en) wlog.push_back(reg_wr_dest);
    end
  end

  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adata,
                       input logic mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdata);
    alu_valid = av; alu_dest = ad; alu_data = adata;
    mem_valid = mv; mem_dest = md; mem_data = mdata;
  endtask

  task automatic expect_write(input string name, input logic en, input logic [ADDR_W-1:0] d,
                              input logic [DATA_W-1:0] data);
    check({name, "_en"}, 32'(reg_wr_en), 32'(en));
    if (en) begin
      check({name, "_dest"}, 32'(reg_wr_dest), 32'(d));
      check({name, "_data"}, 32'(reg_wr_data), 32'(data));
    end
  endtask

  logic mem_stalled;
  logic [ADDR_W-1:0] mq[$], aq[$];

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_mem_ready", 32'(mem_ready), 32'd1);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_wr_dest", 32'(reg_wr_dest), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_pend", 32'(pend_mask), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Single write: accepted at E0, write visible in cycle 2 only.
    drive(1, 3, 16'h1234, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("single_c1_pend", 32'(pend_mask), 32'h08);
    expect_write("single_c1", 0, 0, 0);
    @(negedge clk);
    expect_write("single_c2", 1, 3, 16'h1234);
    check("single_c2_pend", 32'(pend_mask), 32'h08);
    @(negedge clk);
    expect_write("single_c3", 0, 0, 0);
    check("single_c3_pend", 32'(pend_mask), 32'h00);

    // Contention from reset: expected order 1,4,2,5 back to back.
    do_reset();
    drive(1, 1, 16'hA001, 1, 4, 16'hB004);
    @(negedge clk);
    drive(1, 2, 16'hA002, 1, 5, 16'hB005);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    expect_write("cont_w0", 1, 1, 16'hA001);
    @(negedge clk);
    expect_write("cont_w1", 1, 4, 16'hB004);
    @(negedge clk);
    expect_write("cont_w2", 1, 2, 16'hA002);
    @(negedge clk);
    expect_write("cont_w3", 1, 5, 16'hB005);
    repeat (2) @(negedge clk);

    // Backpressure: both sources stream; mem must stall and lose nothing.
    wlog.delete();
    mem_stalled = 1'b0;
    fork
      begin
        int guard;
        for (int k = 0; k < 4; k++) begin
          logic ok;
          mem_valid = 1'b1; mem_dest = ADDR_W'(k + 1); mem_data = DATA_W'(16'hC000 + k);
          guard = 0;
          while (1) begin
            ok = mem_ready;
            if (!ok) mem_stalled = 1'b1;
            @(negedge clk);
            guard++;
            if (ok) break;
            if (guard > 50) begin
              check("bp_mem_timeout", 32'd1, 32'd0);
              break;
            end
          end
        end
        mem_valid = 1'b0;
      end
      begin
        int guard;
        for (int k = 0; k < 3; k++) begin
          logic ok;
          alu_valid = 1'b1; alu_dest = ADDR_W'(k + 5); alu_data = DATA_W'(16'hD000 + k);
          guard = 0;
          while (1) begin
            ok = alu_ready;
            @(negedge clk);
            guard++;
            if (ok) break;
            if (guard > 50) begin
              check("bp_alu_timeout", 32'd1, 32'd0);
              break;
            end
          end
        end
        alu_valid = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    check("bp_mem_stalled", 32'(mem_stalled), 32'd1);
    check("bp_write_count", 32'(wlog.size()), 32'd7);
    foreach (wlog[k]) begin
      if (wlog[k] >= 5) aq.push_back(wlog[k]);
      else mq.push_back(wlog[k]);
    end
    check("bp_mem_count", 32'(mq.size()), 32'd4);
    for (int k = 0; k < 4 && k < mq.size(); k++) check("bp_mem_order", 32'(mq[k]), 32'(k + 1));
    check("bp_alu_count", 32'(aq.size()), 32'd3);
    for (int k = 0; k < 3 && k < aq.size(); k++) check("bp_alu_order", 32'(aq[k]), 32'(k + 5));

    // Register 0 discard: grant consumed, nothing written or flagged.
    drive(0, 0, 0, 1, 0, 16'hFFFF);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("r0_wr_en", 32'(reg_wr_en), 32'd0);
      check("r0_pend", 32'(pend_mask), 32'd0);
      check("r0_err", 32'(err), 32'd0);
      @(negedge clk);
    end

    // Violation: second write to pending register 6 flags err, both still issue.
    drive(1, 6, 16'h6A6A, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 6, 16'h6B6B);
    check("viol_c1_err", 32'(err), 32'd0);
    check("viol_c1_pend", 32'(pend_mask), 32'h40);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("viol_c2_err", 32'(err), 32'd1);
    expect_write("viol_c2", 1, 6, 16'h6A6A);
    @(negedge clk);
    expect_write("viol_c3", 1, 6, 16'h6B6B);
    repeat (5) @(negedge clk);
    check("viol_sticky", 32'(err), 32'd1);

    // Reset mid-flight: write stage active and mem FIFO full.
    do_reset();
    check("rst2_err", 32'(err), 32'd0);
    drive(1, 1, 16'hE001, 1, 2, 16'hE002);
    @(negedge clk);
    drive(1, 3, 16'hE003, 1, 4, 16'hE004);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    expect_write("mid_pre", 1, 1, 16'hE001);
    check("mid_pre_mem_full", 32'(mem_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_async_en", 32'(reg_wr_en), 32'd0);
    check("mid_async_pend", 32'(pend_mask), 32'd0);
    check("mid_async_alu_ready", 32'(alu_ready), 32'd1);
    check("mid_async_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    drive(1, 5, 16'hF005, 1, 6, 16'hF006);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_write("post_tie0", 1, 5, 16'hF005);
    @(negedge clk);
    expect_write("post_tie1", 1, 6, 16'hF006);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
